// File: rtl/layer_priority_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : layer_mux_pkg
// Description : Shared defaults, colour type and index-width helper for the
//               layer priority compositor.
// Revision    : 1.0 - initial release
// ============================================================================
package layer_mux_pkg;

    localparam int c_RGB_W = 8;
    localparam logic [c_RGB_W-1:0] c_TRANSPARENT_KEY = 8'hFF;

    typedef logic [c_RGB_W-1:0] rgb_t;

    // A single layer still needs a 1-bit index port.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_priority_mux_if.sv
`default_nettype none
// ============================================================================
// Module      : layer_priority_mux_if
// Description : Pixel, mask-programming and composited-output bundle between
//               the layer drawers and the compositor.
// Revision    : 1.0 - initial release
// ============================================================================
interface layer_priority_mux_if
    import layer_mux_pkg::*;
#(
    parameter int NUM_LAYERS = 12,
    parameter int RGB_W      = c_RGB_W
);
    localparam int IDX_W = idx_w(NUM_LAYERS);

    logic                             frame_start;
    logic [NUM_LAYERS-1:0]            layer_req;
    logic [NUM_LAYERS-1:0][RGB_W-1:0] layer_rgb;
    logic [RGB_W-1:0]                 default_rgb;
    logic                             mask_wr;
    logic [NUM_LAYERS-1:0]            mask_wdata;
    logic                             blink_wr;
    logic [NUM_LAYERS-1:0]            blink_wdata;
    logic [RGB_W-1:0]                 out_rgb;
    logic [IDX_W-1:0]                 out_layer;
    logic                             out_hit;

    modport master (
        output frame_start, layer_req, layer_rgb, default_rgb,
               mask_wr, mask_wdata, blink_wr, blink_wdata,
        input  out_rgb, out_layer, out_hit
    );

    modport slave (
        input  frame_start, layer_req, layer_rgb, default_rgb,
               mask_wr, mask_wdata, blink_wr, blink_wdata,
        output out_rgb, out_layer, out_hit
    );

endinterface
`default_nettype wire

// File: rtl/layer_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : layer_prio_enc
// Description : Combinational lowest-index-wins priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_prio_enc #(
    parameter int NUM_LAYERS = 12,
    parameter int IDX_W      = 4
) (
    input  wire logic [NUM_LAYERS-1:0] i_qual,
    output logic      [IDX_W-1:0]      o_idx,
    output logic                       o_hit
);

    // Scan from the top down so the lowest qualifying index is the last write.
    always_comb begin
        o_idx = '0;
        o_hit = 1'b0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (i_qual[i]) begin
                o_idx = IDX_W'(i);
                o_hit = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/layer_priority_mux.sv
`default_nettype none
// ============================================================================
// Module      : layer_priority_mux
// Description : Two-stage pipelined layer compositor with transparency key,
//               frame-synchronous enable mask and blink mask.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_priority_mux
    import layer_mux_pkg::*;
#(
    parameter int               NUM_LAYERS      = 12,
    parameter int               RGB_W           = c_RGB_W,
    parameter bit               KEY_EN          = 1'b1,
    parameter logic [RGB_W-1:0] TRANSPARENT_KEY = c_TRANSPARENT_KEY,
    parameter int               BLINK_SHIFT     = 4
) (
    input  wire logic           clk,
    input  wire logic           reset,
    layer_priority_mux_if.slave bus
);

    localparam int IDX_W = idx_w(NUM_LAYERS);

    logic [NUM_LAYERS-1:0] r_mask_shadow;
    logic [NUM_LAYERS-1:0] r_active_mask;
    logic [NUM_LAYERS-1:0] r_blink_shadow;
    logic [NUM_LAYERS-1:0] r_active_blink;
    logic [BLINK_SHIFT:0]  r_frame_cnt;

    logic                  w_blink_phase;
    logic [NUM_LAYERS-1:0] w_qual;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_hit;
    logic [RGB_W-1:0]      w_sel_rgb;

    logic [IDX_W-1:0]      r_s1_idx;
    logic                  r_s1_hit;
    logic [RGB_W-1:0]      r_s1_rgb;
    logic [IDX_W-1:0]      r_out_layer;
    logic                  r_out_hit;
    logic [RGB_W-1:0]      r_out_rgb;

    assign w_blink_phase = r_frame_cnt[BLINK_SHIFT];

    // A layer takes part only if requested, enabled, not in its blink-off
    // phase and not drawing the transparent key colour.
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_qual
        assign w_qual[gi] = bus.layer_req[gi]
                          & r_active_mask[gi]
                          & ~(r_active_blink[gi] & w_blink_phase)
                          & ~(KEY_EN & (bus.layer_rgb[gi] == TRANSPARENT_KEY));
    end

    layer_prio_enc #(
        .NUM_LAYERS (NUM_LAYERS),
        .IDX_W      (IDX_W)
    ) u_enc (
        .i_qual (w_qual),
        .o_idx  (w_idx),
        .o_hit  (w_hit)
    );

    // Colour of the winning layer, falling back to the background colour.
    always_comb begin
        w_sel_rgb = bus.default_rgb;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (w_qual[i]) begin
                w_sel_rgb = bus.layer_rgb[i];
            end
        end
    end

    // Shadow masks take writes any time; active masks load only at frame start,
    // taking a same-cycle write straight through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask_shadow  <= '1;
            r_active_mask  <= '1;
            r_blink_shadow <= '0;
            r_active_blink <= '0;
        end else begin
            if (bus.mask_wr) begin
                r_mask_shadow <= bus.mask_wdata;
            end
            if (bus.blink_wr) begin
                r_blink_shadow <= bus.blink_wdata;
            end
            if (bus.frame_start) begin
                r_active_mask  <= bus.mask_wr  ? bus.mask_wdata  : r_mask_shadow;
                r_active_blink <= bus.blink_wr ? bus.blink_wdata : r_blink_shadow;
            end
        end
    end

    // Free-running frame counter; its top bit is the blink phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
        end else if (bus.frame_start) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    // Stage 1 captures the arbitration result, stage 2 drives the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_idx    <= '0;
            r_s1_hit    <= 1'b0;
            r_s1_rgb    <= '0;
            r_out_layer <= '0;
            r_out_hit   <= 1'b0;
            r_out_rgb   <= '0;
        end else begin
            r_s1_idx    <= w_idx;
            r_s1_hit    <= w_hit;
            r_s1_rgb    <= w_sel_rgb;
            r_out_layer <= r_s1_idx;
            r_out_hit   <= r_s1_hit;
            r_out_rgb   <= r_s1_rgb;
        end
    end

    assign bus.out_rgb   = r_out_rgb;
    assign bus.out_layer = r_out_layer;
    assign bus.out_hit   = r_out_hit;

endmodule
`default_nettype wire

// File: tb/tb_layer_priority_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_priority_mux
// Description : Scoreboard bench for layer_priority_mux with a behavioural
//               compositor model and randomized pixel/mask traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_priority_mux;
    import layer_mux_pkg::*;

    localparam int NL = 12;
    localparam int BS = 1;

    typedef struct {
        logic [7:0] rgb;
        logic [3:0] layer;
        logic       hit;
        int         due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t q[$];

    // stimulus image
    logic [NL-1:0] s_req;
    rgb_t          s_rgb [NL];
    rgb_t          s_def;
    logic          s_mwr;
    logic [NL-1:0] s_mdata;
    logic          s_bwr;
    logic [NL-1:0] s_bdata;
    logic          s_fs;

    // reference model state
    logic [NL-1:0] m_mask_sh;
    logic [NL-1:0] m_mask_act;
    logic [NL-1:0] m_blink_sh;
    logic [NL-1:0] m_blink_act;
    int            m_frame;

    layer_priority_mux_if #(.NUM_LAYERS(NL), .RGB_W(8)) bus ();

    layer_priority_mux #(
        .NUM_LAYERS      (NL),
        .RGB_W           (8),
        .KEY_EN          (1'b1),
        .TRANSPARENT_KEY (8'hFF),
        .BLINK_SHIFT     (BS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count rising edges so expectations can carry a due cycle
    always @(posedge clk) cyc <= cyc + 1;

    task automatic model_reset();
        m_mask_sh   = '1;
        m_mask_act  = '1;
        m_blink_sh  = '0;
        m_blink_act = '0;
        m_frame     = 0;
    endtask

    // Drive one pixel, predict its composited result, then advance the model
    task automatic cycle();
        exp_t e;
        int   phase;
        @(negedge clk);
        bus.layer_req   = s_req;
        for (int i = 0; i < NL; i++) bus.layer_rgb[i] = s_rgb[i];
        bus.default_rgb = s_def;
        bus.mask_wr     = s_mwr;
        bus.mask_wdata  = s_mdata;
        bus.blink_wr    = s_bwr;
        bus.blink_wdata = s_bdata;
        bus.frame_start = s_fs;

        phase   = (m_frame / (1 << BS)) % 2;
        e.rgb   = s_def;
        e.layer = 4'd0;
        e.hit   = 1'b0;
        e.due   = cyc + 2;
        for (int i = 0; i < NL; i++) begin
            if (!e.hit && s_req[i] && m_mask_act[i]
                && !(m_blink_act[i] && phase == 1) && s_rgb[i] != 8'hFF) begin
                e.hit   = 1'b1;
                e.layer = 4'(i);
                e.rgb   = s_rgb[i];
            end
        end
        q.push_back(e);

        if (s_fs) begin
            m_mask_act  = s_mwr ? s_mdata : m_mask_sh;
            m_blink_act = s_bwr ? s_bdata : m_blink_sh;
            m_frame     = m_frame + 1;
        end
        if (s_mwr) m_mask_sh  = s_mdata;
        if (s_bwr) m_blink_sh = s_bdata;
    endtask

    task automatic clear_strobes();
        s_mwr = 1'b0;
        s_bwr = 1'b0;
        s_fs  = 1'b0;
        bus.mask_wr     = 1'b0;
        bus.blink_wr    = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    // Assert reset between edges, check the outputs clear at once, then release
    task automatic apply_reset(input string name);
        exp_t z;
        #2;
        reset = 1'b1;
        clear_strobes();
        #1;
        n_checks++;
        if (bus.out_rgb !== 8'h00 || bus.out_layer !== 4'd0 || bus.out_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got rgb=%h layer=%0d hit=%b, want all zero",
                     name, bus.out_rgb, bus.out_layer, bus.out_hit);
        end
        q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        z.rgb   = 8'h00;
        z.layer = 4'd0;
        z.hit   = 1'b0;
        z.due   = cyc + 1;
        q.push_back(z);
    endtask

    // Monitor: retire every expectation that is due this cycle
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_checks++;
            if (e.due != cyc) begin
                n_fail++;
                $display("FAIL sb_order: entry due %0d retired at cycle %0d", e.due, cyc);
            end else if (bus.out_rgb !== e.rgb || bus.out_layer !== e.layer
                         || bus.out_hit !== e.hit) begin
                n_fail++;
                $display("FAIL pixel@%0d: got rgb=%h layer=%0d hit=%b, want rgb=%h layer=%0d hit=%b",
                         cyc, bus.out_rgb, bus.out_layer, bus.out_hit,
                         e.rgb, e.layer, e.hit);
            end
        end
    end

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        s_req    = '0;
        for (int i = 0; i < NL; i++) s_rgb[i] = 8'h00;
        s_def    = 8'h00;
        s_mdata  = '0;
        s_bdata  = '0;
        bus.layer_req   = '0;
        bus.layer_rgb   = '0;
        bus.default_rgb = '0;
        bus.mask_wdata  = '0;
        bus.blink_wdata = '0;
        clear_strobes();
        model_reset();

        apply_reset("reset_state");

        // background only
        s_def = 8'h24;
        cycle();
        // two requesters, lower index wins
        s_req = '0; s_req[3] = 1'b1; s_req[7] = 1'b1;
        s_rgb[3] = 8'h1C; s_rgb[7] = 8'hE0;
        cycle();
        // transparent key on the higher-priority layer
        s_req = '0; s_req[2] = 1'b1; s_req[5] = 1'b1;
        s_rgb[2] = 8'hFF; s_rgb[5] = 8'h03;
        cycle();

        // disable layer 0 mid-frame; takes effect only after frame_start
        s_req = '0; s_req[0] = 1'b1; s_req[4] = 1'b1;
        s_rgb[0] = 8'h11; s_rgb[4] = 8'h44;
        cycle();
        s_mwr = 1'b1; s_mdata = ~12'h001;
        cycle();
        s_mwr = 1'b0;
        cycle();
        cycle();
        s_fs = 1'b1;
        cycle();
        s_fs = 1'b0;
        cycle();
        s_req[4] = 1'b0;
        cycle();
        cycle();

        // reset during the stream restores the all-ones enable mask
        s_req[4] = 1'b1;
        cycle();
        cycle();
        apply_reset("reset_midstream");
        cycle();
        cycle();

        // blink layer 1 across a full blink period and the counter wrap
        s_req = '0; s_req[1] = 1'b1; s_rgb[1] = 8'h5A;
        s_bwr = 1'b1; s_bdata = 12'h002;
        cycle();
        s_bwr = 1'b0;
        for (int f = 0; f < 6; f++) begin
            s_fs = 1'b1;
            cycle();
            s_fs = 1'b0;
            cycle();
            cycle();
        end

        // randomized traffic with occasional programming and frame pulses
        for (int n = 0; n < 400; n++) begin
            s_req = NL'($urandom);
            for (int i = 0; i < NL; i++)
                s_rgb[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            s_def   = 8'($urandom);
            s_mwr   = ($urandom_range(0, 9) == 0);
            s_mdata = NL'($urandom);
            s_bwr   = ($urandom_range(0, 9) == 0);
            s_bdata = NL'($urandom);
            s_fs    = ($urandom_range(0, 5) == 0);
            cycle();
            if (n == 200) apply_reset("reset_random");
        end
        clear_strobes();

        // bounded drain of the scoreboard
        for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations outstanding, want 0", q.size());
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
